// File: rtl/dpram_sweep_clear.sv
// Row/column addressed dual-port RAM for the line-buffer path.
// Clears by sweeping one word per cycle; adds row clear, write filter and read bypass.
module dpram_sweep_clear #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ROWS       = 4,
    parameter int                    COLS       = 32,
    parameter bit                    SKIP_EN    = 1'b1,
    parameter logic [DATA_WIDTH-1:0] SKIP_VALUE = 8'h7E,
    parameter int                    CNT_WIDTH  = 16,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [RW-1:0]         w_row,
    input  logic [CW-1:0]         w_col,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  re,
    input  logic [RW-1:0]         r_row,
    input  logic [CW-1:0]         r_col,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  r_valid,
    output logic                  r_err,
    input  logic                  clr_req,
    input  logic [RW-1:0]         clr_row,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  skip_cnt
);

    typedef enum logic [1:0] {IDLE, CLR_ALL, CLR_ROW} state_t;

    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

    state_t                state, state_nx;
    logic [RW-1:0]         cur_row, row_nx;
    logic [CW-1:0]         cur_col, col_nx;
    logic [DATA_WIDTH-1:0] mem [ROWS][COLS];

    logic w_in, r_in, skip_hit, w_blocked, w_acc, r_zero;

    function automatic logic row_ok(input logic [RW-1:0] r);
        return int'(r) < ROWS;
    endfunction

    function automatic logic col_ok(input logic [CW-1:0] c);
        return int'(c) < COLS;
    endfunction

    assign busy      = (state != IDLE);
    assign w_in      = row_ok(w_row) && col_ok(w_col);
    assign r_in      = row_ok(r_row) && col_ok(r_col);
    assign skip_hit  = SKIP_EN && we && (din == SKIP_VALUE);
    assign w_blocked = (state == CLR_ALL)
                    || ((state == CLR_ROW) && (w_row == cur_row));
    assign w_acc     = we && w_in && !skip_hit && !w_blocked && !reset;
    // Cells still pending or being cleared read as zero
    assign r_zero    = !r_in || (state == CLR_ALL)
                    || ((state == CLR_ROW) && (r_row == cur_row));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLR_ALL;
            cur_row <= '0;
            cur_col <= '0;
        end else begin
            state   <= state_nx;
            cur_row <= row_nx;
            cur_col <= col_nx;
        end
    end

    always_comb begin
        state_nx = state;
        row_nx   = cur_row;
        col_nx   = cur_col;
        unique case (state)
            IDLE: begin
                if (clr_req && row_ok(clr_row)) begin
                    state_nx = CLR_ROW;
                    row_nx   = clr_row;
                    col_nx   = '0;
                end
            end
            CLR_ALL: begin
                col_nx = cur_col + 1'b1;
                if (cur_col == LAST_COL) begin
                    col_nx = '0;
                    row_nx = cur_row + 1'b1;
                    if (cur_row == LAST_ROW) begin
                        state_nx = IDLE;
                        row_nx   = '0;
                    end
                end
            end
            CLR_ROW: begin
                col_nx = cur_col + 1'b1;
                if (cur_col == LAST_COL) begin
                    state_nx = IDLE;
                    col_nx   = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Clear and user write never hit the same row in one cycle
    always_ff @(posedge clk) begin
        if (busy) mem[cur_row][cur_col] <= '0;
        if (w_acc) mem[w_row][w_col] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout    <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= re;
            r_err   <= re && !r_in;
            if (re) begin
                if (r_zero) dout <= '0;
                else if (w_acc && (w_row == r_row) && (w_col == r_col)) dout <= din;
                else dout <= mem[r_row][r_col];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) skip_cnt <= '0;
        else if (skip_hit && !(&skip_cnt)) skip_cnt <= skip_cnt + 1'b1;
    end

endmodule

// File: tb/tb_dpram_sweep_clear.sv
// Bench for dpram_sweep_clear: cycle model for the 4x32 instance,
// directed literal checks for both the 4x32 and a 3x20 instance.
module tb_dpram_sweep_clear;

    localparam int ROWS = 4;
    localparam int COLS = 32;

    logic        clk;
    logic        reset, we, re, clr_req;
    logic [1:0]  w_row, r_row, clr_row;
    logic [4:0]  w_col, r_col;
    logic [7:0]  din, dout;
    logic        r_valid, r_err, busy;
    logic [15:0] skip_cnt;

    logic        s_reset, s_we, s_re, s_clr_req;
    logic [1:0]  s_w_row, s_r_row, s_clr_row;
    logic [4:0]  s_w_col, s_r_col;
    logic [7:0]  s_din, s_dout;
    logic        s_r_valid, s_r_err, s_busy;
    logic [15:0] s_skip_cnt;

    int total = 0;
    int bad   = 0;

    dpram_sweep_clear u_dut (
        .clk(clk), .reset(reset), .we(we), .w_row(w_row), .w_col(w_col),
        .din(din), .re(re), .r_row(r_row), .r_col(r_col), .dout(dout),
        .r_valid(r_valid), .r_err(r_err), .clr_req(clr_req),
        .clr_row(clr_row), .busy(busy), .skip_cnt(skip_cnt)
    );

    dpram_sweep_clear #(.ROWS(3), .COLS(20)) u_small (
        .clk(clk), .reset(s_reset), .we(s_we), .w_row(s_w_row),
        .w_col(s_w_col), .din(s_din), .re(s_re), .r_row(s_r_row),
        .r_col(s_r_col), .dout(s_dout), .r_valid(s_r_valid),
        .r_err(s_r_err), .clr_req(s_clr_req), .clr_row(s_clr_row),
        .busy(s_busy), .skip_cnt(s_skip_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Model: mode 0 idle, 1 full sweep, 2 row clear; done = cells cleared
    logic [7:0]  m_mem [ROWS][COLS];
    int          m_mode = 0;
    int          m_row  = 0;
    int          m_done = 0;
    logic [7:0]  e_dout = '0;
    logic        e_valid = 1'b0, e_err = 1'b0;
    logic [15:0] e_skip = '0;
    bit          model_ok = 1'b0;

    always @(posedge clk) begin : model
        int  wr, wc, rr, rc;
        bit  hit, acc;
        wr = int'(w_row); wc = int'(w_col);
        rr = int'(r_row); rc = int'(r_col);
        if (reset) begin
            m_mode = 1; m_done = 0; model_ok = 1'b1;
            e_dout = '0; e_valid = 1'b0; e_err = 1'b0; e_skip = '0;
        end else begin
            hit = we && (din == 8'h7E);
            acc = we && !hit && wr < ROWS && wc < COLS && m_mode != 1
               && !(m_mode == 2 && wr == m_row);
            e_valid = re;
            e_err   = re && !(rr < ROWS && rc < COLS);
            if (re) begin
                if (e_err || m_mode == 1 || (m_mode == 2 && rr == m_row))
                    e_dout = '0;
                else if (acc && wr == rr && wc == rc) e_dout = din;
                else e_dout = m_mem[rr][rc];
            end
            if (hit && e_skip != 16'hFFFF) e_skip = e_skip + 16'd1;
            if (acc) m_mem[wr][wc] = din;
            if (m_mode == 1) begin
                m_mem[m_done / COLS][m_done % COLS] = '0;
                m_done++;
                if (m_done == ROWS * COLS) m_mode = 0;
            end else if (m_mode == 2) begin
                m_mem[m_row][m_done] = '0;
                m_done++;
                if (m_done == COLS) m_mode = 0;
            end else if (clr_req && int'(clr_row) < ROWS) begin
                m_mode = 2; m_row = int'(clr_row); m_done = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("dout", 32'(dout), 32'(e_dout));
            check("r_valid", 32'(r_valid), 32'(e_valid));
            check("r_err", 32'(r_err), 32'(e_err));
            check("busy", 32'(busy), 32'(m_mode != 0));
            check("skip_cnt", 32'(skip_cnt), 32'(e_skip));
        end
    end

    task automatic wr(input int r, input int c, input logic [7:0] d);
        we = 1'b1; w_row = 2'(r); w_col = 5'(c); din = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input int r, input int c, input logic [7:0] d,
                      input string nm);
        re = 1'b1; r_row = 2'(r); r_col = 5'(c);
        @(negedge clk);
        re = 1'b0;
        check(nm, 32'(dout), 32'(d));
        check({nm, "_v"}, 32'(r_valid), 32'd1);
    endtask

    task automatic s_rd(input int r, input int c, input logic [7:0] d,
                        input logic err, input string nm);
        s_re = 1'b1; s_r_row = 2'(r); s_r_col = 5'(c);
        @(negedge clk);
        s_re = 1'b0;
        check(nm, 32'(s_dout), 32'(d));
        check({nm, "_err"}, 32'(s_r_err), 32'(err));
        check({nm, "_v"}, 32'(s_r_valid), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b1; we = 1'b0; re = 1'b0; clr_req = 1'b0;
        w_row = '0; w_col = '0; din = '0; r_row = '0; r_col = '0;
        clr_row = '0;
        s_reset = 1'b1; s_we = 1'b0; s_re = 1'b0; s_clr_req = 1'b0;
        s_w_row = '0; s_w_col = '0; s_din = '0; s_r_row = '0;
        s_r_col = '0; s_clr_row = '0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_valid", 32'(r_valid), 32'd0);
        check("rst_skip", 32'(skip_cnt), 32'd0);

        // Full sweep with reads hammering every row
        reset = 1'b0;
        n = 0;
        while (busy && n < 1000) begin
            n++;
            re = 1'b1; r_row = 2'(n); r_col = 5'(n * 7);
            @(negedge clk);
            check("sweep_rd", 32'(dout), 32'd0);
            check("sweep_rd_v", 32'(r_valid), 32'd1);
        end
        re = 1'b0;
        check("sweep_len", 32'(n), 32'd128);
        rd(2, 5, 8'h00, "post_sweep_a");
        rd(3, 31, 8'h00, "post_sweep_b");

        wr(2, 5, 8'h55);
        rd(2, 5, 8'h55, "wr_rd");
        wr(2, 5, 8'h7E);
        rd(2, 5, 8'h55, "filter_keep");
        check("skip_one", 32'(skip_cnt), 32'd1);

        we = 1'b1; w_row = 2'd1; w_col = 5'd1; din = 8'hA3;
        re = 1'b1; r_row = 2'd1; r_col = 5'd1;
        @(negedge clk);
        we = 1'b0; re = 1'b0;
        check("bypass", 32'(dout), 32'hA3);

        for (int c = 0; c < COLS; c++) wr(3, c, 8'h11);
        for (int c = 0; c < COLS; c++) wr(0, c, 8'h22);
        rd(3, 4, 8'h11, "row3_fill");

        clr_req = 1'b1; clr_row = 2'd3;
        @(negedge clk);
        clr_req = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            we = 1'b0; re = 1'b0;
            if (n == 3) begin
                we = 1'b1; w_row = 2'd3; w_col = 5'd0; din = 8'h44;
            end
            if (n == 5) begin
                we = 1'b1; w_row = 2'd0; w_col = 5'd7; din = 8'h66;
                re = 1'b1; r_row = 2'd0; r_col = 5'd2;
            end
            if (n == 6) begin re = 1'b1; r_row = 2'd0; r_col = 5'd7; end
            if (n == 8) begin re = 1'b1; r_row = 2'd3; r_col = 5'd9; end
            @(negedge clk);
            if (n == 5) check("rowclr_rd0", 32'(dout), 32'h22);
            if (n == 6) check("rowclr_wr0", 32'(dout), 32'h66);
            if (n == 8) check("rowclr_rd3", 32'(dout), 32'h00);
        end
        we = 1'b0; re = 1'b0;
        check("rowclr_len", 32'(n), 32'd32);
        rd(3, 0, 8'h00, "row3_c0");
        rd(3, 31, 8'h00, "row3_c31");
        rd(0, 7, 8'h66, "row0_c7");
        rd(0, 2, 8'h22, "row0_c2");

        we = 1'b1; din = 8'h7E;
        for (int i = 0; i < 70000; i++) begin
            w_row = 2'(i); w_col = 5'(i);
            @(negedge clk);
        end
        we = 1'b0;
        check("skip_sat", 32'(skip_cnt), 32'hFFFF);

        // Reset in the middle of a row clear
        wr(1, 2, 8'h99);
        clr_req = 1'b1; clr_row = 2'd2;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_skip", 32'(skip_cnt), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd1);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            we = 1'b0;
            if (n == 20) begin
                we = 1'b1; w_row = 2'd1; w_col = 5'd3; din = 8'h5A;
            end
            @(negedge clk);
        end
        we = 1'b0;
        check("mid_rst_len", 32'(n), 32'd128);
        rd(1, 3, 8'h00, "sweep_wr_lost");
        rd(1, 2, 8'h00, "sweep_cleared");

        // 3x20 instance: range checks and ignored overlapping clear
        s_reset = 1'b0;
        n = 0;
        while (s_busy && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("s_sweep_len", 32'(n), 32'd60);
        check("s_skip", 32'(s_skip_cnt), 32'd0);
        s_we = 1'b1; s_w_row = 2'd3; s_w_col = 5'd0; s_din = 8'h33;
        @(negedge clk);
        s_we = 1'b1; s_w_row = 2'd2; s_w_col = 5'd19; s_din = 8'h5C;
        @(negedge clk);
        s_we = 1'b0;
        s_rd(3, 0, 8'h00, 1'b1, "s_row3");
        s_rd(2, 19, 8'h5C, 1'b0, "s_r2c19");
        s_rd(0, 25, 8'h00, 1'b1, "s_col25");
        s_rd(0, 0, 8'h00, 1'b0, "s_r0c0");
        s_clr_req = 1'b1; s_clr_row = 2'd3;
        @(negedge clk);
        s_clr_req = 1'b0;
        check("s_oob_clr", 32'(s_busy), 32'd0);
        s_clr_req = 1'b1; s_clr_row = 2'd1;
        @(negedge clk);
        s_clr_req = 1'b0;
        n = 0;
        while (s_busy && n < 200) begin
            n++;
            s_clr_req = (n == 5);
            s_clr_row = 2'd2;
            @(negedge clk);
        end
        s_clr_req = 1'b0;
        check("s_clr_len", 32'(n), 32'd20);
        @(negedge clk);
        check("s_no_queue", 32'(s_busy), 32'd0);
        s_rd(2, 19, 8'h5C, 1'b0, "s_r2_kept");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dpram_sweep_clear.md
# dpram_sweep_clear

Parametrised dual-port 2D RAM with one write port and one read port, addressed by row and column, for the display/line-buffer path. It replaces single-cycle bulk reset with a sweep-clear state machine that clears one word per cycle. It also provides per-row clear on command, a configurable write filter with a saturating skip counter, range checking, and write-first bypass. Sits between the character/pixel producer and the scan-out reader.

## Interface

- DATA_WIDTH, 8, width of each word
- ROWS, 4, number of rows; need not be a power of two
- COLS, 32, number of columns; need not be a power of two
- SKIP_EN, 1, 1 = filter writes whose data equals SKIP_VALUE
- SKIP_VALUE, 8'h7E, filtered data value (DATA_WIDTH bits)
- CNT_WIDTH, 16, width of skip_cnt
- RW = max(1,$clog2(ROWS)) and CW = max(1,$clog2(COLS)) are derived localparams

Ports:

- clk  in  1  clock
- reset  in  1  synchronous, active-high; starts a full sweep-clear
- we  in  1  write request
- w_row  in  RW  write row
- w_col  in  CW  write column
- din  in  DATA_WIDTH  write data
- re  in  1  read request
- r_row  in  RW  read row
- r_col  in  CW  read column
- dout  out  DATA_WIDTH  registered read data
- r_valid  out  1  dout valid, one-cycle pulse per read
- r_err  out  1  qualifies r_valid; read address was out of range
- clr_req  in  1  row-clear request, single-cycle pulse
- clr_row  in  RW  row to clear
- busy  out  1  clear sweep in progress (state != IDLE)
- skip_cnt  out  CNT_WIDTH  saturating count of filtered writes

## Operation

- The state machine has three states: IDLE, CLR_ALL and CLR_ROW. Cursor registers are cur_row and cur_col.
- **reset sampled high:**
  - state goes to CLR_ALL with cursor (0,0).
  - dout, r_valid, r_err and skip_cnt go to 0.
  - Reset mid-sweep restarts the sweep from (0,0).
- **CLR_ALL:**
  - Each cycle writes 0 to mem[cur_row][cur_col].
  - cur_col increments; at COLS-1 it wraps to 0 and cur_row increments.
  - After the cell (ROWS-1, COLS-1) is cleared, state goes to IDLE.
- **IDLE + clr_req:**
  - If clr_row < ROWS, state goes to CLR_ROW with cur_row=clr_row and cur_col=0.
  - If clr_row is out of range, the request is ignored.
  - clr_req while busy is ignored; it is not queued.
- **CLR_ROW:** writes 0 to mem[cur_row][cur_col] each cycle. After col COLS-1 is cleared, state goes to IDLE.
- **Write acceptance:** a write with we=1 is accepted only if all of the following hold; otherwise it is silently dropped:
  - w_row < ROWS and w_col < COLS;
  - the write is not filtered;
  - state is not CLR_ALL;
  - state is not CLR_ROW targeting w_row.
- **Write filter:** when SKIP_EN=1 and din == SKIP_VALUE with we=1, the write is dropped. skip_cnt increments and saturates at all-ones. The filter counts regardless of address or busy state.
- **Write in the same cycle as an accepted clr_req:**
  - The write is performed.
  - If the write targets the clr_row, the clear overwrites it one or more cycles later.
- **Reads:** every re=1 produces r_valid=1 on the next cycle.
  - Out of range: dout=0, r_err=1.
  - In CLR_ALL: dout=0.
  - In CLR_ROW with r_row == cur_row: dout=0.
  - Otherwise dout=mem[r_row][r_col], with write-first bypass: if an accepted write targets the same cell in the same cycle, dout=din.
- **dout hold:** when re=0, dout holds its last value.

## Timing

- Read latency is 1 cycle, from re sampled to dout/r_valid/r_err.
- Full sweep:
  - busy=1 on the cycle after reset is sampled high, and stays high while reset is held.
  - After reset deasserts, busy falls exactly ROWS*COLS cycles later (4*32=128 by default).
- Row clear: busy rises the cycle after clr_req and stays high for COLS cycles.
- A memory write lands on the clk edge where it is sampled; a read issued the next cycle sees it.
- **Reset values:**
  - dout=0, r_valid=0, r_err=0, skip_cnt=0
  - busy=1

## Test plan

- **Reset sweep:** pulse reset for 1 cycle, then poll busy.
  - busy stays 1 for 128 cycles, then drops.
  - Reads of any cell afterwards return 0x00.
  - Reads issued during the sweep return 0x00 with r_valid.
- **Write/read and filter:**
  - Write 0x55 to (2,5), then read (2,5): dout=0x55 one cycle later.
  - Write 0x7E to (2,5): a subsequent read still returns 0x55, and skip_cnt=1.
  - 70000 filtered writes: skip_cnt saturates at 0xFFFF.
- **Bypass:** write 0xA3 to (1,1) with a same-cycle read of (1,1) -> next-cycle dout=0xA3.
- **Row clear:** fill row 3 with 0x11 and row 0 with 0x22, then pulse clr_req with clr_row=3.
  - busy is high for 32 cycles.
  - A write of 0x44 to (3,0) during the clear is dropped.
  - Write to and read from row 0 during the clear succeed with 0x22/new data.
  - Afterwards row 3 reads 0x00.
- **Range/overlap, with ROWS=3, COLS=20:**
  - Write to row 3 is dropped.
  - Read of (0,25) gives r_valid=1, r_err=1, dout=0.
  - clr_req during CLR_ROW is ignored; busy drops after the original 20 cycles.
- **Reset mid-operation:** assert reset at cycle 10 of a row clear.
  - A full 128-cycle sweep restarts and skip_cnt resets to 0.
  - A write issued during the sweep is lost.
